tri_s_reg_bank: RTL and testbench
=================================

// Module: tri_s_reg_bank
// PURPOSE
//  Parametrised bank of NUM_REGS registers, each REG_SIZE bits wide, behind one shared tri-state read port.
//  Per-register load and shift-left/right, plus an internal register-to-register MOVE sequenced by a small FSM.
//  Commands arrive on a valid/ready handshake.
//  Sits on a shared datapath bus alongside other tri-state drivers; bus released (all Z) when not enabled.
// PARAMETERS
//  REG_SIZE   8   width of each register and of x/y
//  NUM_REGS   4   number of registers in the bank (>=2; need not be a power of 2)
//  SEL_W      $clog2(NUM_REGS)   width of register index fields (derived, do not override)
// PORTS
//  clk        in   1         single clock; all state updates on rising edge
//  clr        in   1         synchronous, active-high reset
//  cmd_valid  in   1         command present
//  cmd_ready  out  1         bank can accept a command this cycle
//  cmd_op     in   2         00 LOAD, 01 SHL, 10 SHR, 11 MOVE
//  cmd_dst    in   SEL_W     destination register index
//  cmd_src    in   SEL_W     source register index (MOVE only)
//  x          in   REG_SIZE  parallel load data (LOAD only)
//  sin        in   1         serial input bit for SHL/SHR
//  rd_sel     in   SEL_W     register driven onto y
//  en         in   1         output enable for y
//  y          out  REG_SIZE  tri-state read bus: reg[rd_sel] when enabled, else all Z
//  done       out  1         one-cycle pulse: command completed
//  err        out  1         one-cycle pulse: command had an out-of-range index
// BEHAVIOUR
//  Reset (clr=1 at edge): all regs=0, state=IDLE, tmp=0, done=0, err=0; cmd_ready=1 next cycle.
//   clr dominates: a cmd_valid in the same cycle is not accepted.
//   clr mid-MOVE aborts the MOVE; no destination write occurs.
//  Handshake: accept = cmd_valid & cmd_ready. cmd_ready=1 only in IDLE (combinational from state).
//   cmd_* and x are sampled only on accept.
//  LOAD: at accept edge, reg[dst] <= x.
//  SHL: at accept edge, reg[dst] <= {reg[dst][REG_SIZE-2:0], sin}.
//  SHR: at accept edge, reg[dst] <= {sin, reg[dst][REG_SIZE-1:1]}.
//   If REG_SIZE==1, SHL and SHR both give reg[dst] <= sin.
//  LOAD/SHL/SHR: done=1 in the cycle after the accept edge. Back-to-back accepts are allowed every cycle.
//  MOVE FSM, states IDLE -> MOVE_RD -> MOVE_WR -> IDLE:
//   IDLE: on MOVE accept, latch src_q/dst_q and go to MOVE_RD.
//   MOVE_RD edge: tmp <= reg[src_q]; go to MOVE_WR.
//   MOVE_WR edge: reg[dst_q] <= tmp; done=1 next cycle; go to IDLE.
//   A MOVE occupies 3 edges; cmd_ready=0 during MOVE_RD and MOVE_WR.
//   src==dst is legal: value unchanged, full 3-edge timing.
//  Range check: any dst (or src for MOVE) >= NUM_REGS gives:
//   command accepted, no register written, err=1 and done=1 in the cycle after completion.
//   For MOVE, completion is the normal MOVE_WR timing.
//  Read port: y = en ? reg[rd_sel] : {REG_SIZE{1'bz}}.
//   rd_sel >= NUM_REGS drives all Z even with en=1.
//   Read is combinational from registered state: a register written at edge N shows its new value after edge N.
//   No bypass of x to y.
//  done/err are registered and high for exactly one cycle per command.
// STRUCTURE
//  Package tri_s_pkg: opcode localparams OP_LOAD/OP_SHL/OP_SHR/OP_MOVE; state encodings ST_IDLE/ST_MOVE_RD/ST_MOVE_WR.
//  Sub-module tri_s_reg_cell (one REG_SIZE register):
//   inputs clk, clr, wr_en, sel (hold/load/shl/shr), x, sin; output q.
//   Built from the existing df flip-flop per bit.
//   Bank instantiates NUM_REGS cells via generate.
//   Top level holds the FSM, tmp and the index decode.
//  Output drivers reuse the existing tri_sw per bit, enabled by en & (rd_sel < NUM_REGS).
// TESTING
//  1 Reset: clr=1 one cycle with cmd_valid=1 LOAD x=8'hFF -> not accepted; all regs 0; y=Z with en=0; with en=1, rd_sel=0, y=8'h00.
//  2 LOAD/read: LOAD dst=2 x=8'hA5, then en=1 rd_sel=2 -> y=8'hA5 after the accept edge; done high 1 cycle; en=0 -> y=8'hZZ.
//  3 Shift: reg1=8'h81; SHL sin=0 -> 8'h02; then SHR sin=1 -> 8'h81; back-to-back accepts, cmd_ready stays 1.
//  4 MOVE: reg0=8'h3C, MOVE src=0 dst=3 -> cmd_ready low 2 cycles; reg3=8'h3C after 3rd edge; done once.
//   Also MOVE src=dst=0 -> reg0 stays 8'h3C.
//  5 Range (NUM_REGS=3): LOAD dst=3 -> err=1, done=1, no reg changes; rd_sel=3 with en=1 -> y all Z.
//  6 Abort: MOVE src=0 dst=1, clr asserted in MOVE_WR cycle -> reg1=0, state IDLE, done=0, cmd_ready=1 next cycle.

Source files
------------

// File: rtl/tri_s_pkg.sv
// tri_s_pkg: shared definitions for the tri-state register bank.
//   OP_*      command opcodes carried on cmd_op
//   state_t   MOVE sequencer states
//   cell_sel_t per-register update selection (hold/load/shl/shr)
package tri_s_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_MOVE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE_RD = 2'd1,
        ST_MOVE_WR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_SHL  = 2'd2,
        SEL_SHR  = 2'd3
    } cell_sel_t;

endpackage

// File: rtl/df.sv
// df: single D flip-flop with synchronous active-high clear.
//   clk  clock
//   clr  synchronous clear, forces q to 0
//   d    data in
//   q    registered data out
module df (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clr) q <= 1'b0;
        else     q <= d;
    end

endmodule

// File: rtl/tri_s_reg_cell.sv
// tri_s_reg_cell: one REG_SIZE-bit register with load / shift-left / shift-right.
//   clk, clr  clock and synchronous clear
//   wr_en     update enable; when low the register holds
//   sel       update kind (hold/load/shl/shr)
//   x         parallel load data
//   sin       serial input bit for shifts
//   q         register contents
module tri_s_reg_cell
    import tri_s_pkg::*;
#(
    parameter int REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wr_en,
    input  cell_sel_t           sel,
    input  logic [REG_SIZE-1:0] x,
    input  logic                sin,
    output logic [REG_SIZE-1:0] q
);

    logic [REG_SIZE-1:0] d;
    logic [REG_SIZE-1:0] shl_v;
    logic [REG_SIZE-1:0] shr_v;

    // A one-bit register has nothing to shift; both directions just take sin.
    if (REG_SIZE == 1) begin : g_one
        assign shl_v = sin;
        assign shr_v = sin;
    end else begin : g_multi
        assign shl_v = {q[REG_SIZE-2:0], sin};
        assign shr_v = {sin, q[REG_SIZE-1:1]};
    end

    always_comb begin
        d = q;
        if (wr_en) begin
            case (sel)
                SEL_LOAD: d = x;
                SEL_SHL:  d = shl_v;
                SEL_SHR:  d = shr_v;
                default:  d = q;
            endcase
        end
    end

    for (genvar b = 0; b < REG_SIZE; b++) begin : g_bit
        df u_ff (
            .clk (clk),
            .clr (clr),
            .d   (d[b]),
            .q   (q[b])
        );
    end

endmodule

// File: rtl/tri_sw.sv
// tri_sw: single-bit tri-state driver.
//   a   data to drive
//   en  drive enable; when low the output floats
//   y   tri-state output
module tri_sw (
    input  logic      a,
    input  logic      en,
    output wire logic y
);

    assign y = en ? a : 1'bz;

endmodule

// File: rtl/tri_s_reg_bank.sv
// tri_s_reg_bank: NUM_REGS x REG_SIZE register bank behind a shared tri-state read port.
//   clk, clr          clock and synchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_op            LOAD / SHL / SHR / MOVE
//   cmd_dst, cmd_src  register indices (src used by MOVE only)
//   x, sin            load data and serial shift bit
//   rd_sel, en        read select and output enable for y
//   y                 tri-state read bus, all Z when disabled or rd_sel out of range
//   done, err         one-cycle completion / out-of-range pulses
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | accepting commands; LOAD/SHL/SHR complete at accept edge
// ST_MOVE_RD | copying reg[src_q] into tmp
// ST_MOVE_WR | writing tmp into reg[dst_q]
module tri_s_reg_bank
    import tri_s_pkg::*;
#(
    parameter int REG_SIZE = 8,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [SEL_W-1:0]    cmd_dst,
    input  logic [SEL_W-1:0]    cmd_src,
    input  logic [REG_SIZE-1:0] x,
    input  logic                sin,
    input  logic [SEL_W-1:0]    rd_sel,
    input  logic                en,
    output wire logic [REG_SIZE-1:0] y,
    output logic                done,
    output logic                err
);

    state_t              state;
    logic [SEL_W-1:0]    src_q;
    logic [SEL_W-1:0]    dst_q;
    logic [REG_SIZE-1:0] tmp;

    logic [REG_SIZE-1:0] q [NUM_REGS];
    logic                accept;
    logic                cmd_dst_ok;
    logic                cmd_src_ok;
    logic                src_ok_q;
    logic                dst_ok_q;
    logic                rd_ok;
    logic [REG_SIZE-1:0] src_val;
    logic [REG_SIZE-1:0] rd_val;

    logic                wr_go;
    logic [SEL_W-1:0]    wr_idx;
    cell_sel_t           wr_sel;
    logic [REG_SIZE-1:0] wr_data;

    assign cmd_ready  = (state == ST_IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign cmd_dst_ok = int'(cmd_dst) < NUM_REGS;
    assign cmd_src_ok = int'(cmd_src) < NUM_REGS;
    assign src_ok_q   = int'(src_q) < NUM_REGS;
    assign dst_ok_q   = int'(dst_q) < NUM_REGS;
    assign rd_ok      = int'(rd_sel) < NUM_REGS;

    // Index muxes built as loops so an out-of-range index reads 0 instead of
    // walking off the end of the array.
    always_comb begin
        src_val = '0;
        rd_val  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_q == SEL_W'(i))  src_val = q[i];
            if (rd_sel == SEL_W'(i)) rd_val  = q[i];
        end
    end

    // Single write port: MOVE_WR owns it, otherwise an accepted LOAD/SHL/SHR.
    always_comb begin
        wr_go   = 1'b0;
        wr_idx  = cmd_dst;
        wr_sel  = SEL_HOLD;
        wr_data = x;
        if (state == ST_MOVE_WR) begin
            wr_go   = src_ok_q & dst_ok_q;
            wr_idx  = dst_q;
            wr_sel  = SEL_LOAD;
            wr_data = tmp;
        end else if (accept && (cmd_op != OP_MOVE)) begin
            wr_go = cmd_dst_ok;
            case (cmd_op)
                OP_LOAD: wr_sel = SEL_LOAD;
                OP_SHL:  wr_sel = SEL_SHL;
                OP_SHR:  wr_sel = SEL_SHR;
                default: wr_sel = SEL_HOLD;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        tri_s_reg_cell #(.REG_SIZE(REG_SIZE)) u_cell (
            .clk   (clk),
            .clr   (clr),
            .wr_en (wr_go && (wr_idx == SEL_W'(i))),
            .sel   (wr_sel),
            .x     (wr_data),
            .sin   (sin),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
            src_q <= '0;
            dst_q <= '0;
            tmp   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_MOVE) begin
                            src_q <= cmd_src;
                            dst_q <= cmd_dst;
                            state <= ST_MOVE_RD;
                        end else begin
                            done <= 1'b1;
                            err  <= ~cmd_dst_ok;
                        end
                    end
                end
                ST_MOVE_RD: begin
                    tmp   <= src_val;
                    state <= ST_MOVE_WR;
                end
                ST_MOVE_WR: begin
                    done  <= 1'b1;
                    err   <= ~(src_ok_q & dst_ok_q);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Unused in the data path but kept visible for the out-of-range check at accept.
    logic unused_src_ok;
    assign unused_src_ok = cmd_src_ok;

    for (genvar b = 0; b < REG_SIZE; b++) begin : g_drv
        tri_sw u_sw (
            .a  (rd_val[b]),
            .en (en & rd_ok),
            .y  (y[b])
        );
    end

endmodule

// File: tb/tb_tri_s_reg_bank.sv
module tb_tri_s_reg_bank;

    logic       clk = 1'b0;
    logic       clr;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src;
    logic [7:0] x;
    logic       sin;
    logic [1:0] rd_sel;
    logic       en;

    logic       rdy4, done4, err4;
    logic       rdy3, done3, err3;
    wire  [7:0] y4;
    wire  [7:0] y3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tri_s_reg_bank #(.REG_SIZE(8), .NUM_REGS(4)) u_dut4 (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(rdy4),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .x(x), .sin(sin),
        .rd_sel(rd_sel), .en(en), .y(y4), .done(done4), .err(err4)
    );

    tri_s_reg_bank #(.REG_SIZE(8), .NUM_REGS(3)) u_dut3 (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .x(x), .sin(sin),
        .rd_sel(rd_sel), .en(en), .y(y3), .done(done3), .err(err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                       input logic [7:0] data, input logic s);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src   = src;
        x         = data;
        sin       = s;
    endtask

    task automatic rd4(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        en     = 1'b1;
        rd_sel = sel;
        #1;
        chk(tag, y4, exp);
    endtask

    initial begin
        // 1: reset with a LOAD presented; clr must win
        clr = 1'b1; en = 1'b0; rd_sel = 2'd0;
        cmd(2'b00, 2'd0, 2'd0, 8'hFF, 1'b0);
        tick();
        clr = 1'b0; cmd_valid = 1'b0;
        #1;
        chk("rst_ready", {7'd0, rdy4}, 8'h01);
        chk("rst_done",  {7'd0, done4}, 8'h00);
        chk("rst_err",   {7'd0, err4}, 8'h00);
        n_tests++;
        assert (y4 === 8'bzzzzzzzz)
        else begin n_fail++; $error("FAIL rst_y_z observed=%h expected=zz", y4); end
        rd4("rst_reg0", 2'd0, 8'h00);
        rd4("rst_reg3", 2'd3, 8'h00);
        tick();
        chk("rst_done_after", {7'd0, done4}, 8'h00);

        // 2: LOAD and read back, no bypass of x
        cmd(2'b00, 2'd2, 2'd0, 8'hA5, 1'b0);
        rd4("load_no_bypass", 2'd2, 8'h00);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("load_y", y4, 8'hA5);
        chk("load_done", {7'd0, done4}, 8'h01);
        chk("load_err",  {7'd0, err4}, 8'h00);
        tick();
        chk("load_done_1cyc", {7'd0, done4}, 8'h00);
        en = 1'b0;
        #1;
        n_tests++;
        assert (y4 === 8'bzzzzzzzz)
        else begin n_fail++; $error("FAIL load_y_z observed=%h expected=zz", y4); end

        // 3: back-to-back LOAD, SHL, SHR on reg1
        cmd(2'b00, 2'd1, 2'd0, 8'h81, 1'b0);
        tick();
        cmd(2'b01, 2'd1, 2'd0, 8'h00, 1'b0);
        chk("shl_ready", {7'd0, rdy4}, 8'h01);
        tick();
        cmd(2'b10, 2'd1, 2'd0, 8'h00, 1'b1);
        rd4("shl_val", 2'd1, 8'h02);
        chk("shl_done", {7'd0, done4}, 8'h01);
        chk("shr_ready", {7'd0, rdy4}, 8'h01);
        tick();
        cmd_valid = 1'b0;
        rd4("shr_val", 2'd1, 8'h81);
        chk("shr_done", {7'd0, done4}, 8'h01);
        tick();
        chk("shr_done_end", {7'd0, done4}, 8'h00);

        // 4: MOVE reg0 -> reg3
        cmd(2'b00, 2'd0, 2'd0, 8'h3C, 1'b0);
        tick();
        cmd(2'b11, 2'd3, 2'd0, 8'h00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("mv_ready_rd", {7'd0, rdy4}, 8'h00);
        chk("mv_done_rd",  {7'd0, done4}, 8'h00);
        rd4("mv_reg3_rd", 2'd3, 8'h00);
        tick();
        chk("mv_ready_wr", {7'd0, rdy4}, 8'h00);
        rd4("mv_reg3_wr", 2'd3, 8'h00);
        tick();
        rd4("mv_reg3", 2'd3, 8'h3C);
        chk("mv_done", {7'd0, done4}, 8'h01);
        chk("mv_err",  {7'd0, err4}, 8'h00);
        chk("mv_ready_back", {7'd0, rdy4}, 8'h01);
        tick();
        chk("mv_done_1cyc", {7'd0, done4}, 8'h00);

        // MOVE with src == dst
        cmd(2'b11, 2'd0, 2'd0, 8'h00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mv_same_ready", {7'd0, rdy4}, 8'h00);
        tick();
        rd4("mv_same_val", 2'd0, 8'h3C);
        chk("mv_same_done", {7'd0, done4}, 8'h01);

        // 5: range checks on the 3-register bank
        tick();
        cmd(2'b00, 2'd3, 2'd0, 8'h55, 1'b0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("rng_err",  {7'd0, err3}, 8'h01);
        chk("rng_done", {7'd0, done3}, 8'h01);
        chk("rng4_err", {7'd0, err4}, 8'h00);
        en = 1'b1; rd_sel = 2'd2;
        #1;
        chk("rng_reg2", y3, 8'hA5);
        rd_sel = 2'd0;
        #1;
        chk("rng_reg0", y3, 8'h3C);
        rd_sel = 2'd3;
        #1;
        n_tests++;
        assert (y3 === 8'bzzzzzzzz)
        else begin n_fail++; $error("FAIL rng_y_z observed=%h expected=zz", y3); end
        chk("rng4_reg3", y4, 8'h55);
        tick();
        chk("rng_err_1cyc", {7'd0, err3}, 8'h00);
        // out-of-range MOVE source: full MOVE timing, no write
        cmd(2'b11, 2'd0, 2'd3, 8'h00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rng_mv_err",  {7'd0, err3}, 8'h01);
        chk("rng_mv_done", {7'd0, done3}, 8'h01);
        rd_sel = 2'd0;
        #1;
        chk("rng_mv_reg0", y3, 8'h3C);

        // 6: clr during MOVE_WR aborts the MOVE
        tick();
        cmd(2'b11, 2'd1, 2'd0, 8'h00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        chk("abort_done",  {7'd0, done4}, 8'h00);
        chk("abort_ready", {7'd0, rdy4}, 8'h01);
        rd4("abort_reg1", 2'd1, 8'h00);
        rd4("abort_reg0", 2'd0, 8'h00);
        tick();
        chk("abort_done_next", {7'd0, done4}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
